// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO: read pointer (binary + Gray), memory read port,
// empty flag and a valid/ready output stage. Define FIFO_RD_OCC_EN to build the occupancy counter.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int AE_THRESH  = 4,
    localparam int PTR_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_WIDTH-1:0]  rq2_wptr,
    output logic [PTR_WIDTH-1:0]  rptr,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_ren,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH-1:0]  rd_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_WIDTH-1:0] rbin_q, rbin_d;
    logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
    logic                 empty_q, empty_d;

    if (AE_THRESH < 0 || AE_THRESH >= (1 << PTR_WIDTH)) begin : g_bad_thresh
        $error("AE_THRESH must fit in the pointer range");
    end

    function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // The next word is fetched whenever the output slot is free or being drained this cycle.
    always_comb begin
        mem_ren = !empty_q && ((state_q == IDLE) || rd_ready);
        rbin_d  = rbin_q + {{(PTR_WIDTH-1){1'b0}}, mem_ren};
        rptr_d  = bin2gray(rbin_d);
        empty_d = (rptr_d == rq2_wptr);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_ren) state_d = VALID;
            VALID:   if (!mem_ren && rd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rbin_q  <= '0;
            rptr_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rbin_q  <= rbin_d;
            rptr_q  <= rptr_d;
            empty_q <= empty_d;
        end
    end

    assign rptr      = rptr_q;
    assign mem_raddr = rbin_q[ADDR_WIDTH-1:0];
    assign rd_valid  = (state_q == VALID);
    assign empty     = empty_q;

`ifdef FIFO_RD_OCC_EN
    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] rd_count_q, rd_count_d;
    logic                 almost_empty_q, almost_empty_d;

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
        for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Uses the synchronized (stale) write pointer, so the count can only under-report.
    always_comb begin
        wbin           = gray2bin(rq2_wptr);
        rd_count_d     = wbin - rbin_d;
        almost_empty_d = (rd_count_d <= PTR_WIDTH'(AE_THRESH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q     <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            rd_count_q     <= rd_count_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign rd_count     = rd_count_q;
    assign almost_empty = almost_empty_q;
`else
    assign rd_count     = '0;
    assign almost_empty = empty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a behavioural memory supplies rdata = addr*3+1 and a
// consumer process checks every accepted word against the expected address sequence.
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] rq2_wptr;
    logic [8:0] rptr;
    logic [7:0] mem_raddr;
    logic       mem_ren;
    logic       rd_valid;
    logic       rd_ready;
    logic       empty;
    logic       almost_empty;
    logic [8:0] rd_count;

    logic [7:0] rdata;
    logic [7:0] exp_addr = 8'd0;
    int         n_acc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic [8:0] prev_rptr;
    int         acc_base;

    always #5 clk = ~clk;

    fifo_rd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rq2_wptr     (rq2_wptr),
        .rptr         (rptr),
        .mem_raddr    (mem_raddr),
        .mem_ren      (mem_ren),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return 8'(a * 3 + 1);
    endfunction

    always @(posedge clk) begin
        if (mem_ren) rdata <= mem_word(mem_raddr);
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_addr = 8'd0;
        end else if (rd_valid && rd_ready) begin
            chk("data", {24'd0, rdata}, {24'd0, mem_word(exp_addr)});
            exp_addr = exp_addr + 8'd1;
            n_acc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [8:0] wptr, input logic rdy);
        rst      = 1'b1;
        rq2_wptr = wptr;
        rd_ready = rdy;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rq2_wptr = 9'h005;
        rd_ready = 1'b1;

        // Reset with a non-empty write pointer
        repeat (3) tick();
        chk("rst_rptr", {23'd0, rptr}, 32'h0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_ren", {31'd0, mem_ren}, 32'd0);
        chk("rst_count", {23'd0, rd_count}, 32'd0);
        chk("rst_ae", {31'd0, almost_empty}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rel_empty", {31'd0, empty}, 32'd0);
        chk("rel_ren", {31'd0, mem_ren}, 32'd1);
        chk("rel_addr", {24'd0, mem_raddr}, 32'h0);
        chk("rel_valid0", {31'd0, rd_valid}, 32'd0);
        tick();
        chk("rel_valid1", {31'd0, rd_valid}, 32'd1);

        // Streaming 8 words
        do_reset(9'h00C, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("strm_ren", {31'd0, mem_ren}, 32'd1);
            chk("strm_addr", {24'd0, mem_raddr}, i);
            tick();
            chk("strm_valid", {31'd0, rd_valid}, 32'd1);
        end
        chk("strm_empty", {31'd0, empty}, 32'd1);
        chk("strm_rptr", {23'd0, rptr}, 32'h00C);
        chk("strm_ren_end", {31'd0, mem_ren}, 32'd0);
        tick();
        chk("strm_valid_fall", {31'd0, rd_valid}, 32'd0);

        // Backpressure with 4 words available
        do_reset(9'h006, 1'b0);
        acc_base = n_acc;
        tick();
        chk("bp_prefetch", {31'd0, mem_ren}, 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rd_valid}, 32'd1);
            chk("bp_ren", {31'd0, mem_ren}, 32'd0);
            chk("bp_addr", {24'd0, mem_raddr}, 32'h1);
            tick();
        end
        rd_ready = 1'b1;
        #1;
        for (int i = 1; i < 4; i++) begin
            chk("bp_drain_ren", {31'd0, mem_ren}, 32'd1);
            chk("bp_drain_addr", {24'd0, mem_raddr}, i);
            tick();
        end
        tick();
        tick();
        chk("bp_count", n_acc - acc_base, 32'd4);
        chk("bp_idle", {31'd0, rd_valid}, 32'd0);

        // Wrap: drain 0x1FE words, then offer 4 more across the pointer rollover
        do_reset(9'h101, 1'b1);
        tick();
        for (int i = 0; i < 700; i++) begin
            if (empty && !rd_valid) break;
            tick();
        end
        chk("wrap_pre_rptr", {23'd0, rptr}, 32'h101);
        chk("wrap_pre_empty", {31'd0, empty}, 32'd1);
        rq2_wptr = 9'h003;
        tick();
        chk("wrap_empty_fall", {31'd0, empty}, 32'd0);
        begin
            logic [7:0] addrs [4];
            logic [8:0] grays [4];
            addrs = '{8'hFE, 8'hFF, 8'h00, 8'h01};
            grays = '{9'h100, 9'h000, 9'h001, 9'h003};
            for (int i = 0; i < 4; i++) begin
                chk("wrap_ren", {31'd0, mem_ren}, 32'd1);
                chk("wrap_addr", {24'd0, mem_raddr}, {24'd0, addrs[i]});
                prev_rptr = rptr;
                tick();
                chk("wrap_rptr", {23'd0, rptr}, {23'd0, grays[i]});
                chk("wrap_1bit", $countones(prev_rptr ^ rptr), 32'd1);
                chk("wrap_empty", {31'd0, empty}, (i == 3) ? 32'd1 : 32'd0);
            end
        end
        tick();
        tick();

        // Occupancy: Gray(10) offered, count then 5 and 6 reads
        do_reset(9'h00F, 1'b1);
        tick();
`ifdef FIFO_RD_OCC_EN
        chk("occ_10", {23'd0, rd_count}, 32'd10);
        chk("occ_ae_10", {31'd0, almost_empty}, 32'd0);
`else
        chk("occ_off_0", {23'd0, rd_count}, 32'd0);
        chk("occ_off_ae0", {31'd0, almost_empty}, 32'd0);
`endif
        repeat (5) tick();
`ifdef FIFO_RD_OCC_EN
        chk("occ_5", {23'd0, rd_count}, 32'd5);
        chk("occ_ae_5", {31'd0, almost_empty}, 32'd0);
`endif
        tick();
`ifdef FIFO_RD_OCC_EN
        chk("occ_4", {23'd0, rd_count}, 32'd4);
        chk("occ_ae_4", {31'd0, almost_empty}, 32'd1);
`else
        chk("occ_off_1", {23'd0, rd_count}, 32'd0);
        chk("occ_off_ae1", {31'd0, almost_empty}, {31'd0, empty});
`endif
        repeat (5) tick();
`ifndef FIFO_RD_OCC_EN
        chk("occ_off_ae_empty", {31'd0, almost_empty}, 32'd1);
`endif

        // Reset mid-stream with 3 words left
        do_reset(9'h005, 1'b1);
        tick();
        repeat (3) tick();
        chk("mid_valid_pre", {31'd0, rd_valid}, 32'd1);
        chk("mid_addr_pre", {24'd0, mem_raddr}, 32'h3);
        rst      = 1'b1;
        rd_ready = 1'b0;
        tick();
        chk("mid_valid", {31'd0, rd_valid}, 32'd0);
        chk("mid_rptr", {23'd0, rptr}, 32'h0);
        chk("mid_empty", {31'd0, empty}, 32'd1);
        chk("mid_ren", {31'd0, mem_ren}, 32'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain controller for the async FIFO.
- Owns the read pointer (binary and Gray) and drives the dual-port memory read port.
- Derives empty and occupancy from the write pointer, which arrives Gray-coded through the 2-flop pointer synchronizer.
- Presents read data to the consumer through a valid/ready handshake, with full throughput and a 1-cycle memory read latency.

Parameters:
- ADDR_WIDTH, 8, memory address width; depth = 2**ADDR_WIDTH.
- PTR_WIDTH, ADDR_WIDTH+1, pointer width (extra wrap bit). Not overridable independently.
- AE_THRESH, 4, almost_empty asserts when occupancy <= AE_THRESH.

Ports:
- clk  input  1  read-domain clock.
- rst  input  1  synchronous, active-high reset.
- rq2_wptr  input  PTR_WIDTH  write pointer, Gray, already synchronized into clk domain.
- rptr  output  PTR_WIDTH  read pointer, Gray, registered; goes to the write-domain synchronizer.
- mem_raddr  output  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0].
- mem_ren  output  1  memory read enable; combinational.
- rd_valid  output  1  memory read data is valid for the consumer.
- rd_ready  input  1  consumer accepts data.
- empty  output  1  registered empty flag.
- almost_empty  output  1  registered; see Optional Feature.
- rd_count  output  PTR_WIDTH  registered occupancy; see Optional Feature.

Behaviour:
- Reset values (rst high at a clk edge): rbin=0, rptr=0, empty=1, rd_valid=0, almost_empty=1, rd_count=0, state=IDLE. Reset has priority over all events. Mid-stream reset drops the in-flight word; the consumer must not rely on it.
- Pointer update:
  - mem_ren = !empty && (!rd_valid || rd_ready).
  - rbin_next = rbin + mem_ren, modulo 2**PTR_WIDTH.
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rbin <= rbin_next and rptr <= rgray_next every cycle.
- Empty: empty <= (rgray_next == rq2_wptr). Comparison is Gray to Gray, over all PTR_WIDTH bits.
- Memory contract:
  - Memory registers rdata on a clk edge where mem_ren=1.
  - Memory holds rdata when mem_ren=0.
  - The controller has no data path.
- FSM, two states:
  - IDLE: rd_valid=0.
  - VALID: rd_valid=1.
  - IDLE -> VALID when mem_ren=1.
  - VALID -> VALID when mem_ren=1 (accept plus refill in the same cycle) or when rd_ready=0 (hold).
  - VALID -> IDLE when rd_ready=1 and mem_ren=0 (accepted, FIFO empty).
- Latency and throughput:
  - First word: rd_valid rises 1 cycle after the cycle where empty=0 and mem_ren=1.
  - With rd_ready held high, one word per cycle.
- Handshake: while rd_valid=1 and rd_ready=0, mem_ren=0, the pointer is stable and the data is held.
- Wrap-around:
  - rbin wraps from 2**PTR_WIDTH-1 to 0.
  - mem_raddr wraps every depth reads.
  - The wrap bit distinguishes full laps.
- Simultaneous events:
  - A write arriving in the same cycle as the last read leaves empty=1 for that edge.
  - Empty deasserts on the first edge after rq2_wptr differs from rgray_next. This is pessimistic and safe.
- No underflow is possible: mem_ren is gated by empty.
- The read pointer advances only by 0 or 1 per cycle, so rptr changes at most one bit per cycle (synchronizer-safe).

Optional Feature:
- Macro: FIFO_RD_OCC_EN.
- Defined:
  - wbin = Gray-to-binary(rq2_wptr), combinational XOR prefix.
  - rd_count <= wbin - rbin_next, modulo 2**PTR_WIDTH.
  - almost_empty <= (that value <= AE_THRESH).
  - Both reset to 0 and 1 respectively.
  - rd_count is pessimistic by the synchronizer latency; it never exceeds true occupancy.
- Undefined:
  - rd_count tied to 0, almost_empty tied to empty.
  - No Gray decoder or subtractor is synthesized.

Test Plan:
- Reset: hold rst=1 for 3 cycles with rq2_wptr=9'h005 -> rptr=0, empty=1, rd_valid=0, mem_ren=0. Release -> empty falls on the next edge, mem_ren=1 with mem_raddr=0, rd_valid=1 one cycle later.
- Streaming: rq2_wptr = Gray(8), rd_ready=1 -> 8 consecutive mem_ren pulses, addresses 0..7. empty=1 on the edge after the 8th read. rptr ends at 9'h00C (Gray 8). rd_valid falls one cycle after the last read.
- Backpressure: 4 words available, rd_ready=0 for 5 cycles after the first valid -> rd_valid held at 1, mem_ren=0, mem_raddr=1 stable. Then rd_ready=1 -> remaining words at one per cycle, no loss or duplication.
- Wrap: preload rbin=9'h1FE via traffic, rq2_wptr advanced 4 beyond -> mem_raddr sequence FE, FF, 00, 01. rptr goes Gray(1FE) -> Gray(1FF) -> 0 -> 1 (Gray 0x001), one bit changing per step. Empty is correct at the wrap-bit rollover.
- Occupancy (FIFO_RD_OCC_EN defined), AE_THRESH=4: rq2_wptr = Gray(10), no reads -> rd_count=10, almost_empty=0. After 6 reads -> rd_count=4, almost_empty=1. Undefined -> rd_count=0, almost_empty tracks empty.
- Reset mid-stream: assert rst while rd_valid=1 and 3 words remain -> next cycle rd_valid=0, rptr=0, empty=1, regardless of rd_ready.
